// File: rtl/ysyx_25040101_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: FSM states, owner
// encoding and the default response timeout.
package ysyx_25040101_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int CNT_W           = 16;

endpackage

// File: rtl/ysyx_25040101_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on a tie the requester
// that was not granted last time wins. Purely combinational, one-hot output.
module ysyx_25040101_rr_arb2
  import ysyx_25040101_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = (last_grant == OWN_LSU) ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/ysyx_25040101_mem_arb.sv
// Arbitrates IFU and LSU requests onto one downstream memory port, one
// outstanding transaction at a time, with a forced error after TIMEOUT cycles.
module ysyx_25040101_mem_arb
  import ysyx_25040101_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_valid,
  output logic        ifu_ready,
  input  logic [31:0] ifu_addr,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        ifu_rvalid,
  output logic        lsu_rvalid,
  output logic [31:0] rdata,
  output logic        rerr,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rerr
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_t           state;
  owner_t           owner;
  owner_t           last_grant;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      lat_addr;
  logic             lat_wen;
  logic [31:0]      lat_wdata;
  logic [3:0]       lat_wmask;
  logic [31:0]      rdata_hold;
  logic             rerr_hold;

  logic [1:0] grant;
  logic       in_idle;
  logic       in_req;
  logic       in_wait;
  logic       resp_real;
  logic       resp_tmo;
  logic       resp;

  // Gating with rst keeps every handshake output low during the reset cycle.
  assign in_idle = rst && (state == S_IDLE);
  assign in_req  = rst && (state == S_REQ);
  assign in_wait = rst && (state == S_WAIT);

  ysyx_25040101_rr_arb2 u_rr (
    .req        ({lsu_valid && in_idle, ifu_valid && in_idle}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign ifu_ready = grant[0];
  assign lsu_ready = grant[1];

  // A real response in the timeout cycle takes priority over the forced error.
  assign resp_real = in_wait && mem_rvalid;
  assign resp_tmo  = in_wait && !mem_rvalid && (cnt == TMO);
  assign resp      = resp_real || resp_tmo;

  assign ifu_rvalid = resp && (owner == OWN_IFU);
  assign lsu_rvalid = resp && (owner == OWN_LSU);
  assign rdata      = resp_real ? mem_rdata : (resp_tmo ? 32'd0 : rdata_hold);
  assign rerr       = resp_real ? mem_rerr  : (resp_tmo ? 1'b1  : rerr_hold);

  assign mem_valid = in_req;
  assign mem_wen   = in_req && lat_wen;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign mem_wmask = lat_wmask;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      owner      <= OWN_IFU;
      last_grant <= OWN_LSU;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_wen    <= 1'b0;
      lat_wdata  <= '0;
      lat_wmask  <= '0;
      rdata_hold <= '0;
      rerr_hold  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant[0]) begin
            owner      <= OWN_IFU;
            last_grant <= OWN_IFU;
            lat_addr   <= ifu_addr;
            lat_wen    <= 1'b0;
            lat_wdata  <= '0;
            lat_wmask  <= '0;
            cnt        <= '0;
            state      <= S_REQ;
          end else if (grant[1]) begin
            owner      <= OWN_LSU;
            last_grant <= OWN_LSU;
            lat_addr   <= lsu_addr;
            lat_wen    <= lsu_wen;
            lat_wdata  <= lsu_wdata;
            lat_wmask  <= lsu_wmask;
            cnt        <= '0;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (cnt != TMO) cnt <= cnt + 1'b1;
          if (mem_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (resp) begin
            rdata_hold <= rdata;
            rerr_hold  <= rerr;
            state      <= S_IDLE;
          end else if (cnt != TMO) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040101_mem_arb.sv
// Directed bench for the memory arbiter: a transaction-level model checks all
// outputs every cycle, and hand-computed literals pin the key scenarios.
module tb_ysyx_25040101_mem_arb;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_valid = 1'b0;
  logic        ifu_ready;
  logic [31:0] ifu_addr = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [31:0] lsu_addr = '0;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic        ifu_rvalid;
  logic        lsu_rvalid;
  logic [31:0] rdata;
  logic        rerr;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rerr = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  ysyx_25040101_mem_arb #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_addr(ifu_addr),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .ifu_rvalid(ifu_rvalid), .lsu_rvalid(lsu_rvalid), .rdata(rdata), .rerr(rerr),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rerr(mem_rerr)
  );

  always #5 clk = ~clk;

  // Transaction-level model: one outstanding request, aged in cycles since grant.
  bit          m_busy = 0;
  bit          m_accepted = 0;
  int          m_age = 0;
  bit          m_owner = 0;
  bit          m_last = 1;
  logic [31:0] m_addr = '0;
  logic        m_wen = 0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_wmask = '0;
  logic [31:0] m_rdata = '0;
  logic        m_rerr = 0;

  always @(negedge clk) begin
    logic        e_ir, e_lr, e_resp, e_mv, e_wen, e_rerr;
    logic [31:0] e_rdata;
    logic [106:0] exp_v, act_v;
    if (started) begin
      e_ir = 0; e_lr = 0; e_resp = 0; e_mv = 0; e_wen = 0;
      e_rdata = m_rdata; e_rerr = m_rerr;
      if (rst) begin
        if (!m_busy) begin
          if (ifu_valid && (!lsu_valid || m_last == 1'b1)) e_ir = 1;
          else if (lsu_valid) e_lr = 1;
        end else if (!m_accepted) begin
          e_mv = 1; e_wen = m_wen;
        end else if (mem_rvalid) begin
          e_resp = 1; e_rdata = mem_rdata; e_rerr = mem_rerr;
        end else if (m_age - 1 >= TMO) begin
          e_resp = 1; e_rdata = 32'd0; e_rerr = 1;
        end
      end
      exp_v = {e_ir, e_lr, e_resp && !m_owner, e_resp && m_owner, e_rdata, e_rerr,
               e_mv, m_addr, e_wen, m_wdata, m_wmask};
      act_v = {ifu_ready, lsu_ready, ifu_rvalid, lsu_rvalid, rdata, rerr,
               mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL model t=%0t got %h expected %h", $time, act_v, exp_v);
      end
      if (!rst) begin
        m_busy = 0; m_accepted = 0; m_age = 0; m_owner = 0; m_last = 1;
        m_addr = '0; m_wen = 0; m_wdata = '0; m_wmask = '0; m_rdata = '0; m_rerr = 0;
      end else begin
        if (e_resp) begin
          m_rdata = e_rdata; m_rerr = e_rerr; m_busy = 0;
        end else if (m_busy) begin
          if (!m_accepted && mem_ready) m_accepted = 1;
          m_age++;
        end
        if (e_ir) begin
          m_busy = 1; m_accepted = 0; m_age = 1; m_owner = 0; m_last = 0;
          m_addr = ifu_addr; m_wen = 0; m_wdata = '0; m_wmask = '0;
        end else if (e_lr) begin
          m_busy = 1; m_accepted = 0; m_age = 1; m_owner = 1; m_last = 1;
          m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  int order[$];
  int exp_order[4];

  initial begin
    exp_order = '{0, 1, 0, 1};
    // reset
    @(posedge clk); #1; started = 1;
    smp;
    chk("rst_ifu_ready", {31'd0, ifu_ready}, 32'd0);
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    cyc; rst = 1;

    // round-robin with both requesters held valid
    ifu_valid = 1; ifu_addr = 32'h8000_0040;
    lsu_valid = 1; lsu_addr = 32'h8000_2000;
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h1111_2222;
    for (int i = 0; i < 12; i++) begin
      smp;
      if (ifu_ready) order.push_back(0);
      if (lsu_ready) order.push_back(1);
      cyc;
    end
    chk("rr_grant_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < order.size()) chk($sformatf("rr_grant_%0d", i), 32'(order[i]), 32'(exp_order[i]));
    ifu_valid = 0; lsu_valid = 0; mem_rvalid = 0;
    cyc; cyc;

    // minimum-latency IFU fetch
    ifu_valid = 1; ifu_addr = 32'h8000_0000; mem_ready = 1;
    smp; chk("fetch_ready", {31'd0, ifu_ready}, 32'd1);
    cyc; ifu_valid = 0;
    smp; chk("fetch_mem_valid", {31'd0, mem_valid}, 32'd1);
    chk("fetch_mem_addr", mem_addr, 32'h8000_0000);
    chk("fetch_mem_wen", {31'd0, mem_wen}, 32'd0);
    cyc; mem_rvalid = 1; mem_rdata = 32'h0000_0413; mem_rerr = 0;
    smp; chk("fetch_rvalid", {31'd0, ifu_rvalid}, 32'd1);
    chk("fetch_rdata", rdata, 32'h0000_0413);
    chk("fetch_rerr", {31'd0, rerr}, 32'd0);
    chk("fetch_lsu_rvalid", {31'd0, lsu_rvalid}, 32'd0);
    cyc; mem_rvalid = 0;
    smp; chk("fetch_pulse_end", {31'd0, ifu_rvalid}, 32'd0);
    chk("fetch_rdata_hold", rdata, 32'h0000_0413);
    cyc;

    // LSU store with mem_ready stalled three cycles; real response beats timeout
    lsu_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF; mem_ready = 0;
    smp; chk("store_ready", {31'd0, lsu_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      cyc; mem_ready = (k == 3);
      smp;
      chk($sformatf("store_valid_%0d", k), {31'd0, mem_valid}, 32'd1);
      chk($sformatf("store_addr_%0d", k), mem_addr, 32'h8000_1000);
      chk($sformatf("store_wdata_%0d", k), mem_wdata, 32'hDEAD_BEEF);
      chk($sformatf("store_wmask_%0d", k), {28'd0, mem_wmask}, 32'hF);
      chk($sformatf("store_wen_%0d", k), {31'd0, mem_wen}, 32'd1);
      chk($sformatf("store_lsu_ready_%0d", k), {31'd0, lsu_ready}, 32'd0);
    end
    cyc; lsu_valid = 0; lsu_wen = 0; mem_ready = 0;
    mem_rvalid = 1; mem_rdata = 32'h1234_5678; mem_rerr = 0;
    smp; chk("store_rvalid", {31'd0, lsu_rvalid}, 32'd1);
    chk("store_rdata", rdata, 32'h1234_5678);
    chk("store_rerr", {31'd0, rerr}, 32'd0);
    cyc; mem_rvalid = 0;

    // timeout: request accepted, response never arrives
    ifu_valid = 1; ifu_addr = 32'h8000_0100; mem_ready = 1;
    smp; chk("tmo_ready", {31'd0, ifu_ready}, 32'd1);
    cyc; ifu_valid = 0;
    smp; chk("tmo_mem_valid", {31'd0, mem_valid}, 32'd1);
    for (int k = 1; k < TMO; k++) begin
      cyc; smp; chk($sformatf("tmo_quiet_%0d", k), {31'd0, ifu_rvalid}, 32'd0);
    end
    cyc; smp;
    chk("tmo_rvalid", {31'd0, ifu_rvalid}, 32'd1);
    chk("tmo_rerr", {31'd0, rerr}, 32'd1);
    chk("tmo_rdata", rdata, 32'd0);
    cyc; ifu_valid = 1; ifu_addr = 32'h8000_0180;
    smp; chk("tmo_back_idle", {31'd0, ifu_ready}, 32'd1);
    chk("tmo_rerr_hold", {31'd0, rerr}, 32'd1);

    // reset during WAIT aborts the transaction
    cyc; ifu_valid = 0;
    cyc; rst = 0;
    smp; chk("abort_no_pulse", {31'd0, ifu_rvalid}, 32'd0);
    cyc; rst = 1; mem_rvalid = 1; mem_rdata = 32'h0000_0BAD;
    ifu_valid = 1; ifu_addr = 32'h8000_0200;
    smp; chk("abort_ignored", {30'd0, ifu_rvalid, lsu_rvalid}, 32'd0);
    chk("abort_new_ready", {31'd0, ifu_ready}, 32'd1);
    chk("abort_rdata", rdata, 32'd0);
    cyc; ifu_valid = 0; mem_rvalid = 0; mem_ready = 1;
    smp; chk("abort_next_addr", mem_addr, 32'h8000_0200);
    cyc; mem_rvalid = 1; mem_rdata = 32'hCAFE_0001; mem_rerr = 0;
    smp; chk("abort_next_resp", rdata, 32'hCAFE_0001);
    cyc;

    // spurious response while idle
    mem_rdata = 32'h5555_5555; mem_rerr = 1;
    smp; chk("spur_rvalid", {30'd0, ifu_rvalid, lsu_rvalid}, 32'd0);
    chk("spur_rdata", rdata, 32'hCAFE_0001);
    chk("spur_rerr", {31'd0, rerr}, 32'd0);
    cyc; mem_rvalid = 0; mem_rerr = 0;
    cyc; cyc;
    smp;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_25040101_mem_arb.md
YSYX_25040101_MEM_ARB -- requirements
Module: ysyx_25040101_mem_arb

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles WAIT may last before forced error response (1..65535).
REQ-002 Ports: clk  in  1  single clock, all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-low reset (0 = reset), sampled on clk rising edge.
REQ-004 ifu_valid/ifu_ready  in/out  1/1  IFU request handshake; ifu_addr  in  32  fetch address (read only).
REQ-005 lsu_valid/lsu_ready  in/out  1/1  LSU request handshake; lsu_addr  in  32; lsu_wen  in  1; lsu_wdata  in  32; lsu_wmask  in  4.
REQ-006 ifu_rvalid/lsu_rvalid  out  1  one-cycle response pulse to owner; rdata  out  32  shared response data; rerr  out  1  response error flag.
REQ-007 mem_valid  out  1; mem_ready  in  1; mem_addr  out  32; mem_wen  out  1; mem_wdata  out  32; mem_wmask  out  4  downstream request channel.
REQ-008 mem_rvalid  in  1; mem_rdata  in  32; mem_rerr  in  1  downstream response channel.

Function
REQ-009 FSM states IDLE, REQ, WAIT; plus owner (0=IFU,1=LSU) and last_grant registers.
REQ-010 IDLE, one requester valid: that requester granted; both valid: requester != last_grant granted (round-robin).
REQ-011 Grant in IDLE: granted *_ready=1 combinationally same cycle; handshake = valid&ready; request fields latched into internal regs; owner and last_grant updated; next state REQ.
REQ-012 *_ready SHALL be 0 in REQ and WAIT and for the non-granted requester; at most one ready high per cycle.
REQ-013 IFU grant latches wen=0, wdata=0, wmask=0; LSU grant latches lsu fields verbatim.
REQ-014 REQ: mem_valid=1, mem_* driven from latched regs, stable until mem_valid&mem_ready; then next state WAIT.
REQ-015 WAIT: mem_valid=0; on mem_rvalid: owner's *_rvalid=1 for exactly that cycle, rdata=mem_rdata, rerr=mem_rerr, next state IDLE.
REQ-016 Timeout counter cleared on entry to REQ, increments each cycle in REQ or WAIT; on reaching TIMEOUT without mem_rvalid: owner *_rvalid=1, rdata=0, rerr=1, next IDLE.
REQ-017 mem_rvalid in same cycle as timeout: real response wins, rerr=mem_rerr.
REQ-018 mem_rvalid outside WAIT SHALL be ignored (no rvalid pulse, no state change).
REQ-019 Response cycle and next grant never coincide: new grant earliest one cycle after *_rvalid (IDLE cycle).
REQ-020 Minimum latency: grant cycle N, mem_valid N+1, with mem_ready=1 and mem_rvalid next cycle, *_rvalid at N+2.
REQ-021 rdata/rerr hold last response value outside response cycles; mem_addr/wdata/wmask hold latched values outside REQ.

Reset
REQ-022 rst=0 at rising edge: state=IDLE, owner=0, last_grant=1 (IFU wins first tie), counter=0, latched regs=0.
REQ-023 Reset outputs: all *_ready, *_rvalid, mem_valid, mem_wen, rerr = 0; rdata, mem_addr, mem_wdata, mem_wmask = 0.
REQ-024 Reset mid-transaction (REQ or WAIT) aborts it: no response pulse issued; subsequent mem_rvalid for aborted request ignored per REQ-018.

Structure
REQ-025 State encoding (IDLE/REQ/WAIT), owner encoding and default TIMEOUT belong in shared package ysyx_25040101_pkg.
REQ-026 Round-robin grant logic SHALL be sub-module ysyx_25040101_rr_arb2 (2 requests, last_grant in, one-hot grant out, combinational).

Verification
REQ-027 IFU only, addr 0x80000000, mem_ready=1, mem_rvalid rdata 0x00000413 next cycle -> ifu_rvalid pulse at grant+2, rdata 0x00000413, rerr=0, lsu_rvalid=0.
REQ-028 Both valid after reset -> IFU granted first; both held valid -> LSU next, then IFU; grant order I,D,I,D.
REQ-029 LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF, mem_ready low 3 cycles -> mem_* stable all 4 REQ cycles, mem_wen=1, lsu_ready low throughout.
REQ-030 TIMEOUT=4, mem_ready=1, mem_rvalid never -> owner rvalid with rerr=1, rdata=0 exactly at cycle 4 after entering REQ; FSM returns IDLE.
REQ-031 rst=0 during WAIT, then mem_rvalid=1 -> no rvalid pulse, state IDLE, ifu_ready responds to new request next cycle.
REQ-032 Spurious mem_rvalid in IDLE -> no *_rvalid, rdata unchanged.
